vector_addsub_nx1: RTL and testbench

- Sequential n-element signed vector adder/subtractor for the fixed-point Kalman datapath.
- Sits directly downstream of the nx1 matrix-vector multiplier and consumes its result vector. Typical uses: innovation y = z - H*x, and state update x = x_pred + K*y.
- Processes one element per clock, saturates each result to WIDTH bits, and reports overflow.
- Uses the same start/end pulse handshake as the multiplier, so the multiplier's end pulse can drive this block's start directly.

---
 rtl/kalman_pkg.sv | 44 ++++
 rtl/sat_addsub.sv | 36 +++
 rtl/vector_addsub_nx1.sv | 135 +++++++++++++
 tb/tb_vector_addsub_nx1.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared Kalman datapath types and saturation helpers
//
// Purpose: the stage-control state enum used by the multiplier and add/sub
//          stages, the saturation limits for the default element width, and
//          a reference saturating add/sub helper at that width.
// Ports:   none (package).
package kalman_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SAT_WIDTH = 16;

  localparam logic signed [SAT_WIDTH-1:0] MAX_POS = {1'b0, {(SAT_WIDTH-1){1'b1}}};
  localparam logic signed [SAT_WIDTH-1:0] MAX_NEG = {1'b1, {(SAT_WIDTH-1){1'b0}}};

  // Returns {ovf, result}. One guard bit is enough to hold any sum or
  // difference of two SAT_WIDTH operands exactly, so the guard and sign
  // bits disagree exactly when the true result is out of range.
  function automatic logic [SAT_WIDTH:0] sat_add(
    input logic signed [SAT_WIDTH-1:0] a,
    input logic signed [SAT_WIDTH-1:0] b,
    input logic                        sub
  );
    logic signed [SAT_WIDTH:0]   s;
    logic        [SAT_WIDTH-1:0] y;
    logic                        o;
    s = sub ? ({a[SAT_WIDTH-1], a} - {b[SAT_WIDTH-1], b})
            : ({a[SAT_WIDTH-1], a} + {b[SAT_WIDTH-1], b});
    o = s[SAT_WIDTH] ^ s[SAT_WIDTH-1];
    if (!o) begin
      y = s[SAT_WIDTH-1:0];
    end else if (s[SAT_WIDTH]) begin
      y = MAX_NEG;
    end else begin
      y = MAX_POS;
    end
    return {o, y};
  endfunction

endpackage

// File: rtl/sat_addsub.sv
// rtl/sat_addsub.sv - combinational saturating add/sub of one signed element
//
// Purpose: y = sat(a + b) or sat(a - b) at WIDTH bits, ovf when clamped.
// Ports:
//   a, b  in  WIDTH  signed operands
//   sub   in  1      0: a + b, 1: a - b
//   y     out WIDTH  saturated result
//   ovf   out 1      result was clamped to max positive / max negative
module sat_addsub #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  logic signed [WIDTH:0] s;

  always_comb begin
    s   = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
              : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
    // Guard bit is the true sign; a disagreement with bit WIDTH-1 means
    // the value does not fit in WIDTH bits.
    ovf = s[WIDTH] ^ s[WIDTH-1];
    if (!ovf) begin
      y = s[WIDTH-1:0];
    end else if (s[WIDTH]) begin
      y = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      y = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/vector_addsub_nx1.sv
// rtl/vector_addsub_nx1.sv - sequential saturating n-element vector add/sub
//
// Purpose: Res = A +/- B element by element, one element per clock, for the
//          fixed-point Kalman datapath (innovation and state update).
// Ports:
//   clk       in  1            rising-edge clock
//   rst_n     in  1            asynchronous active-low reset
//   startAdd  in  1            start request, honoured only when idle
//   subMode   in  1            0: A + B, 1: A - B (captured with startAdd)
//   A, B      in  WIDTH x nos  operand vectors (captured with startAdd)
//   Res       out WIDTH x nos  registered result vector
//   ovf       out 1            sticky saturation flag for current operation
//   busy      out 1            operation in progress (RUN or DONE)
//   endAdd    out 1            one-cycle completion pulse
module vector_addsub_nx1
  import kalman_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int nos       = 4,
  parameter int intDigits = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    startAdd,
  input  logic                    subMode,
  input  logic signed [WIDTH-1:0] A   [0:nos-1],
  input  logic signed [WIDTH-1:0] B   [0:nos-1],
  output logic signed [WIDTH-1:0] Res [0:nos-1],
  output logic                    ovf,
  output logic                    busy,
  output logic                    endAdd
);

  // The fixed-point format only matters for consistency with neighbouring
  // stages; add/sub of same-format operands is format-agnostic.
  if (nos < 1 || intDigits < 1 || intDigits > WIDTH) begin : g_bad_cfg
    $error("vector_addsub_nx1: illegal nos/intDigits configuration");
  end

  localparam int               IDX_W    = (nos > 1) ? $clog2(nos) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(nos - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic signed [WIDTH-1:0] a_cap [0:nos-1];
  logic signed [WIDTH-1:0] b_cap [0:nos-1];
  logic                    sub_cap;
  logic signed [WIDTH-1:0] elem_y;
  logic                    elem_ovf;
  logic                    last_elem;

  assign last_elem = (idx == LAST_IDX);

  // Single element unit, time-multiplexed over the captured operands.
  sat_addsub #(
    .WIDTH(WIDTH)
  ) u_sat_addsub (
    .a  (a_cap[idx]),
    .b  (b_cap[idx]),
    .sub(sub_cap),
    .y  (elem_y),
    .ovf(elem_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    endAdd    = 1'b0;
    case (state)
      IDLE: begin
        if (startAdd) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_elem) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        endAdd    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      sub_cap <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < nos; i++) begin
        a_cap[i] <= '0;
        b_cap[i] <= '0;
        Res[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (startAdd) begin
            sub_cap <= subMode;
            ovf     <= 1'b0;
            idx     <= '0;
            for (int i = 0; i < nos; i++) begin
              a_cap[i] <= A[i];
              b_cap[i] <= B[i];
              Res[i]   <= '0;
            end
          end
        end
        RUN: begin
          Res[idx] <= elem_y;
          if (elem_ovf) begin
            ovf <= 1'b1;
          end
          idx <= last_elem ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_addsub_nx1.sv
// tb/tb_vector_addsub_nx1.sv - self-checking bench for vector_addsub_nx1
module tb_vector_addsub_nx1;

  localparam int WIDTH = 16;
  localparam int NOS   = 4;

  typedef logic signed [WIDTH-1:0] vec_t [0:NOS-1];

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic startAdd = 1'b0;
  logic subMode  = 1'b0;
  vec_t A;
  vec_t B;
  logic signed [WIDTH-1:0] Res [0:NOS-1];
  logic ovf;
  logic busy;
  logic endAdd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vector_addsub_nx1 #(
    .WIDTH    (WIDTH),
    .nos      (NOS),
    .intDigits(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .startAdd(startAdd),
    .subMode (subMode),
    .A       (A),
    .B       (B),
    .Res     (Res),
    .ovf     (ovf),
    .busy    (busy),
    .endAdd  (endAdd)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted operation started at posedge s_cyc makes Res[i] final from
  // posedge s_cyc+i+1 (zero before that), keeps the block busy through
  // s_cyc+nos, pulses endAdd after s_cyc+nos, and accepts a new start
  // only from posedge s_cyc+nos+2 onward.
  int cyc    = 0;
  int s_cyc  = 0;
  bit have_op = 1'b0;
  int cur_res [NOS];
  bit cur_ov  [NOS];

  function automatic int sat_ref(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_op = 1'b0;
    end else if (startAdd && (!have_op || (cyc - s_cyc) >= NOS + 2)) begin
      have_op = 1'b1;
      s_cyc   = cyc;
      for (int i = 0; i < NOS; i++) begin
        int raw;
        raw        = subMode ? (int'(A[i]) - int'(B[i])) : (int'(A[i]) + int'(B[i]));
        cur_res[i] = sat_ref(raw);
        cur_ov[i]  = (raw != cur_res[i]);
      end
    end
  end

  int  m_d;
  int  m_res;
  bit  m_ovf;

  always @(negedge clk) begin
    m_d   = cyc - s_cyc;
    m_ovf = 1'b0;
    for (int i = 0; i < NOS; i++) begin
      m_res = (have_op && m_d >= i + 1) ? cur_res[i] : 0;
      if (have_op && m_d >= i + 1 && cur_ov[i]) m_ovf = 1'b1;
      check($sformatf("model res[%0d] cyc %0d", i, cyc), Res[i], m_res);
    end
    check($sformatf("model ovf cyc %0d", cyc), ovf, m_ovf);
    check($sformatf("model busy cyc %0d", cyc), busy, (have_op && m_d <= NOS) ? 1 : 0);
    check($sformatf("model endAdd cyc %0d", cyc), endAdd, (have_op && m_d == NOS) ? 1 : 0);
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input vec_t a, input vec_t b, input logic sub, output int lat);
    @(negedge clk);
    #1;
    A        = a;
    B        = b;
    subMode  = sub;
    startAdd = 1'b1;
    lat      = -1;
    for (int j = 1; j <= 20 && lat < 0; j++) begin
      @(negedge clk);
      if (endAdd) lat = j;
      #1 startAdd = 1'b0;
    end
  endtask

  task automatic check_vec(input string tag, input vec_t exp, input logic exp_ovf);
    for (int i = 0; i < NOS; i++) begin
      check($sformatf("%s res[%0d]", tag, i), Res[i], exp[i]);
    end
    check($sformatf("%s ovf", tag), ovf, exp_ovf);
  endtask

  vec_t a1, b1, e1, a2, b2, e_add2, e_sub2, a_ch, bm, e_ch, bm_lit;
  int   lat;
  int   n_end;
  int   M [NOS][NOS];
  int   v [NOS];

  initial begin
    a1     = '{10, -20, 300, 0};
    b1     = '{5, 5, -300, 7};
    e1     = '{15, -15, 0, 7};
    a2     = '{100, -200, 32767, -32768};
    b2     = '{50, 300, 1, 1};
    e_add2 = '{150, 100, 32767, -32767};
    e_sub2 = '{50, -500, 32766, -32768};
    A      = a1;
    B      = b1;

    // reset state
    repeat (3) @(negedge clk);
    check_vec("reset", '{0, 0, 0, 0}, 1'b0);
    check("reset busy", busy, 0);
    check("reset endAdd", endAdd, 0);
    #1 rst_n = 1'b1;

    // plain add
    do_op(a1, b1, 1'b0, lat);
    check("add latency", lat, 5);
    check_vec("add", e1, 1'b0);

    // add with saturation
    do_op(a2, b2, 1'b0, lat);
    check("sat add latency", lat, 5);
    check_vec("sat add", e_add2, 1'b1);

    // subtract with negative saturation
    do_op(a2, b2, 1'b1, lat);
    check("sat sub latency", lat, 5);
    check_vec("sat sub", e_sub2, 1'b1);

    // start while busy, operand capture, start during endAdd
    @(negedge clk);
    #1 A = a1; B = b1; subMode = 1'b0; startAdd = 1'b1;
    @(negedge clk);
    #1 startAdd = 1'b0; A = a2; B = b2; subMode = 1'b1;
    @(negedge clk);
    #1 startAdd = 1'b1;
    @(negedge clk);
    #1 startAdd = 1'b0;
    n_end = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (endAdd) begin
        n_end++;
        #1 startAdd = 1'b1;
      end else begin
        #1 startAdd = 1'b0;
      end
    end
    check("busy-start endAdd count", n_end, 1);
    check_vec("busy-start capture", e1, 1'b0);
    check("busy-start idle after", busy, 0);

    // reset during the second RUN cycle
    @(negedge clk);
    #1 A = a2; B = b2; subMode = 1'b1; startAdd = 1'b1;
    @(negedge clk);
    #1 startAdd = 1'b0;
    @(negedge clk);
    check("pre-reset res[0]", Res[0], 50);
    #1 rst_n = 1'b0;
    #1;
    check_vec("mid reset", '{0, 0, 0, 0}, 1'b0);
    check("mid reset busy", busy, 0);
    check("mid reset endAdd", endAdd, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    n_end = 0;
    repeat (6) begin
      @(negedge clk);
      if (endAdd) n_end++;
    end
    check("post-reset spurious endAdd", n_end, 0);
    do_op(a1, b1, 1'b0, lat);
    check("post-reset latency", lat, 5);
    check_vec("post-reset add", e1, 1'b0);

    // chained after a behavioural matrix-vector multiplier: x = A + M*v
    M      = '{'{1, 2, 0, 0}, '{0, 1, -1, 0}, '{3, 0, 0, 1}, '{0, 0, 2, 2}};
    v      = '{10, 20, 30, -5};
    a_ch   = '{1, 2, 3, 4};
    bm_lit = '{50, -10, 25, 50};
    e_ch   = '{51, -8, 28, 54};
    for (int r = 0; r < NOS; r++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < NOS; c++) acc += M[r][c] * v[c];
      bm[r] = WIDTH'(acc);
    end
    for (int r = 0; r < NOS; r++) check($sformatf("mult res[%0d]", r), bm[r], bm_lit[r]);
    repeat (NOS + 1) @(negedge clk);
    // the multiplier's end pulse drives startAdd, its Res drives B
    do_op(a_ch, bm, 1'b0, lat);
    check("chain latency after endMult", lat, 5);
    check_vec("chain", e_ch, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1);
  end

endmodule
